// File: rtl/lsu_ctrl_if.sv
// Bus bundle for lsu_ctrl: MEM-stage request/response plus the data_mem port.
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32
) ();
    // Request transfers on the rising edge where req_valid && req_ready; the requester keeps
    // its fields stable while req_valid is high. resp_valid is a one-cycle pulse and cannot
    // be stalled by the consumer.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [31:0]           req_base;
    logic [31:0]           req_offset;
    logic [31:0]           req_wdata;
    logic [4:0]            req_rd;

    logic                  resp_valid;
    logic                  resp_is_load;
    logic [31:0]           resp_rdata;
    logic [4:0]            resp_rd;
    logic [1:0]            resp_fault;
    logic [31:0]           resp_addr;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [2:0]            mem_op;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data_wr;
    logic [31:0]           mem_data_rd;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_is_load, resp_rdata, resp_rd, resp_fault, resp_addr,
        output mem_rd_en, mem_wr_en, mem_op, mem_addr, mem_data_wr,
        input  mem_data_rd
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_is_load, resp_rdata, resp_rd, resp_fault, resp_addr,
        input  mem_rd_en, mem_wr_en, mem_op, mem_addr, mem_data_wr,
        output mem_data_rd
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: word-only memory traffic, lane extraction for sub-word loads and
// read-modify-write for sub-word stores, one registered response per request.
module lsu_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus,
    output logic [2:0] dbg_state
);
    localparam logic [2:0] MEM_LW = 3'b010;
    localparam logic [2:0] MEM_SW = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_ISSUE = 3'd1,
        LD_DONE  = 3'd2,
        ST_ISSUE = 3'd3,
        RMW_RD   = 3'd4,
        RMW_WR   = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]            f3_q;
    logic [31:0]           ea_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;
    logic                  is_store_q;

    logic                  accept;
    logic [31:0]           ea;
    logic                  legal;
    logic                  misaligned;
    logic [1:0]            fault_code;

    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;
    logic [31:0]           word_addr;

    logic                  resp_set;
    logic                  resp_is_load_d;
    logic [DATA_WIDTH-1:0] resp_rdata_d;
    logic [4:0]            resp_rd_d;
    logic [1:0]            resp_fault_d;
    logic [31:0]           resp_addr_d;

    logic                  resp_valid_q;
    logic                  resp_is_load_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic [4:0]            resp_rd_q;
    logic [1:0]            resp_fault_q;
    logic [31:0]           resp_addr_q;

    assign accept = bus.req_valid && (state == IDLE);
    assign ea     = bus.req_base + bus.req_offset;

    // Illegal funct3 is decided first so it masks any alignment complaint.
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        fault_code = 2'b00;
        if (bus.req_is_store) begin
            legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                    (bus.req_funct3 == 3'b010);
        end else begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && ea[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        if (!legal) begin
            fault_code = 2'b10;
        end else if (misaligned) begin
            fault_code = 2'b01;
        end
    end

    always_comb begin
        lane_byte = bus.mem_data_rd[{ea_q[1:0], 3'b000} +: 8];
        lane_half = bus.mem_data_rd[{ea_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = bus.mem_data_rd;
        endcase
        merged = bus.mem_data_rd;
        if (f3_q[1:0] == 2'b00) begin
            merged[{ea_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{ea_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    assign word_addr = {ea_q[31:2], 2'b00};
    assign bus.mem_addr = word_addr[ADDR_WIDTH-1:0];

    always_comb begin
        state_next      = state;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_op      = 3'b000;
        bus.mem_data_wr = '0;
        resp_set        = 1'b0;
        resp_is_load_d  = !is_store_q;
        resp_rdata_d    = '0;
        resp_rd_d       = rd_q;
        resp_fault_d    = 2'b00;
        resp_addr_d     = ea_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault_code != 2'b00) begin
                        // Faults answer straight from the accept edge, no memory traffic.
                        resp_set       = 1'b1;
                        resp_is_load_d = !bus.req_is_store;
                        resp_rd_d      = bus.req_rd;
                        resp_fault_d   = fault_code;
                        resp_addr_d    = ea;
                    end else if (!bus.req_is_store) begin
                        state_next = LD_ISSUE;
                    end else if (bus.req_funct3 == 3'b010) begin
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LD_ISSUE: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_op    = MEM_LW;
                state_next    = LD_DONE;
            end
            LD_DONE: begin
                bus.mem_op   = MEM_LW;
                resp_set     = 1'b1;
                resp_rdata_d = load_data;
                state_next   = IDLE;
            end
            ST_ISSUE: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_op      = MEM_SW;
                bus.mem_data_wr = wdata_q;
                resp_set        = 1'b1;
                state_next      = IDLE;
            end
            RMW_RD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_op    = MEM_LW;
                state_next    = RMW_WR;
            end
            RMW_WR: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_op      = MEM_SW;
                bus.mem_data_wr = merged;
                resp_set        = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q       <= 3'b000;
            ea_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
        end else if (accept) begin
            f3_q       <= bus.req_funct3;
            ea_q       <= ea;
            wdata_q    <= bus.req_wdata;
            rd_q       <= bus.req_rd;
            is_store_q <= bus.req_is_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q   <= 1'b0;
            resp_is_load_q <= 1'b0;
            resp_rdata_q   <= '0;
            resp_rd_q      <= '0;
            resp_fault_q   <= 2'b00;
            resp_addr_q    <= '0;
        end else begin
            resp_valid_q <= resp_set;
            if (resp_set) begin
                resp_is_load_q <= resp_is_load_d;
                resp_rdata_q   <= resp_rdata_d;
                resp_rd_q      <= resp_rd_d;
                resp_fault_q   <= resp_fault_d;
                resp_addr_q    <= resp_addr_d;
            end
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_is_load = resp_is_load_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_rd      = resp_rd_q;
    assign bus.resp_fault   = resp_fault_q;
    assign bus.resp_addr    = resp_addr_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: word memory beside the DUT, byte-addressed reference memory in the
// checker, directed spec cases, a reset abort and randomized traffic.
module tb_lsu_ctrl;
    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    int         n_checks;
    int         n_fail;

    lsu_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        int          lat;
        int          nrd;
        int          nwr;
        int          op_err;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [1:0]  fault;
        logic        is_load;
        logic [4:0]  rd;
    } obs_t;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] e_rdata;
        logic [1:0]  e_fault;
        int          e_lat;
        int          e_nrd;
        int          e_nwr;
        logic [31:0] e_wrdata;
    } dir_t;

    function automatic logic [31:0] init_word(int i);
        if (i == 32'h80) return 32'h11223344;
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // data_mem stand-in: registered read, write on the strobe edge, 1 KiB window.
    logic [31:0] dmem [0:255];
    bit          mem_loaded;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (bus.mem_rd_en) bus.mem_data_rd <= dmem[bus.mem_addr[9:2]];
            if (bus.mem_wr_en) dmem[bus.mem_addr[9:2]] <= bus.mem_data_wr;
        end
    end

    // Reference model: byte-addressed memory and architectural load/store rules.
    logic [7:0] ref_mem [0:1023];

    function automatic int size_of(logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(logic [31:0] ea);
        logic [31:0] w;
        int a;
        a = int'(ea[9:0]) & ~3;
        w = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        return w;
    endfunction

    task automatic ref_store(input logic [31:0] ea, input logic [2:0] f3, input logic [31:0] wd);
        int a;
        a = int'(ea[9:0]);
        for (int i = 0; i < size_of(f3); i++) ref_mem[a+i] = wd[8*i +: 8];
    endtask

    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] ea,
                         input logic [31:0] wd, output logic [31:0] e_rdata,
                         output logic [1:0] e_fault, output int e_lat, output int e_nrd,
                         output int e_nwr, output logic [31:0] e_wrdata);
        int          size;
        logic        legal;
        logic [31:0] v;
        size     = size_of(f3);
        legal    = st ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 <= 3'd5));
        e_fault  = !legal ? 2'b10 : ((ea & (size - 1)) != 0) ? 2'b01 : 2'b00;
        e_rdata  = '0;
        e_wrdata = '0;
        e_lat    = 1;
        e_nrd    = 0;
        e_nwr    = 0;
        if (e_fault == 2'b00) begin
            if (!st) begin
                v = '0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(ea[9:0]) + i]) << (8 * i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
                e_rdata = v;
                e_lat   = 3;
                e_nrd   = 1;
            end else begin
                ref_store(ea, f3, wd);
                e_wrdata = ref_word(ea);
                e_lat    = (size == 4) ? 2 : 3;
                e_nrd    = (size == 4) ? 0 : 1;
                e_nwr    = 1;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge that shows the response.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                          output obs_t o);
        o.ready  = bus.req_ready;
        o.lat    = 0;
        o.nrd    = 0;
        o.nwr    = 0;
        o.op_err = 0;
        o.rd_addr = '0;
        o.wr_addr = '0;
        o.wr_data = '0;
        o.rdata  = '0;
        o.addr   = '0;
        o.fault  = '0;
        o.is_load = 1'b0;
        o.rd     = '0;
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en && bus.mem_wr_en) o.op_err++;
            if ((bus.mem_rd_en || bus.mem_wr_en) && bus.mem_op !== 3'b010) o.op_err++;
            if (bus.mem_rd_en) begin
                o.nrd++;
                o.rd_addr = bus.mem_addr;
            end
            if (bus.mem_wr_en) begin
                o.nwr++;
                o.wr_addr = bus.mem_addr;
                o.wr_data = bus.mem_data_wr;
            end
            if (bus.resp_valid) begin
                if (bus.mem_op !== 3'b000) o.op_err++;
                o.rdata   = bus.resp_rdata;
                o.addr    = bus.resp_addr;
                o.fault   = bus.resp_fault;
                o.is_load = bus.resp_is_load;
                o.rd      = bus.resp_rd;
                o.lat     = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.resp_valid, bus.resp_is_load, bus.resp_rdata, bus.resp_rd, bus.resp_fault,
             bus.resp_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: got valid=%b rdata=%h fault=%b addr=%h want all 0",
                     bus.resp_valid, bus.resp_rdata, bus.resp_fault, bus.resp_addr);
        end
        n_checks++;
        if ({bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.mem_op} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b rd=%b wr=%b op=%b want 1 0 0 000",
                     bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.mem_op);
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got valid=%b ready=%b want 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    dir_t tbl [0:12];

    task automatic test_directed();
        obs_t        ob;
        logic [31:0] ea;
        tbl[0]  = '{1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 32'h0, 2'b00, 2, 0, 1, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'b010, 32'h0FC, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF, 2'b00, 3, 1, 0, 32'h0};
        tbl[2]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 5'd6, 32'hFFFFFFDE, 2'b00, 3, 1, 0, 32'h0};
        tbl[3]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h0, 5'd7, 32'h000000DE, 2'b00, 3, 1, 0, 32'h0};
        tbl[4]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h0, 5'd8, 32'hFFFFDEAD, 2'b00, 3, 1, 0, 32'h0};
        tbl[5]  = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h0, 5'd9, 32'h0000BEEF, 2'b00, 3, 1, 0, 32'h0};
        tbl[6]  = '{1'b1, 3'b000, 32'h101, 32'h0, 32'h00000055, 5'd1, 32'h0, 2'b00, 3, 1, 1, 32'hDEAD55EF};
        tbl[7]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd10, 32'hDEAD55EF, 2'b00, 3, 1, 0, 32'h0};
        tbl[8]  = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 5'd11, 32'h0, 2'b01, 1, 0, 0, 32'h0};
        tbl[9]  = '{1'b0, 3'b011, 32'h101, 32'h0, 32'h0, 5'd12, 32'h0, 2'b10, 1, 0, 0, 32'h0};
        tbl[10] = '{1'b1, 3'b100, 32'h100, 32'h0, 32'h12345678, 5'd13, 32'h0, 2'b10, 1, 0, 0, 32'h0};
        tbl[11] = '{1'b0, 3'b010, 32'h108, 32'hFFFFFFF8, 32'h0, 5'd0, 32'hDEAD55EF, 2'b00, 3, 1, 0, 32'h0};
        tbl[12] = '{1'b1, 3'b001, 32'h200, 32'h2, 32'h1234ABCD, 5'd14, 32'h0, 2'b00, 3, 1, 1, 32'hABCD3344};
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            ea = tbl[i].base + tbl[i].off;
            if (tbl[i].st && tbl[i].e_fault == 2'b00) ref_store(ea, tbl[i].f3, tbl[i].wd);
            do_req(tbl[i].st, tbl[i].f3, tbl[i].base, tbl[i].off, tbl[i].wd, tbl[i].rd, ob);
            n_checks++;
            if (ob.ready !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d ready: got %b want 1", i, ob.ready);
            end
            n_checks++;
            if (ob.lat !== tbl[i].e_lat) begin
                n_fail++; $display("FAIL dir%0d latency: got %0d want %0d", i, ob.lat, tbl[i].e_lat);
            end
            n_checks++;
            if (ob.rdata !== tbl[i].e_rdata || ob.fault !== tbl[i].e_fault) begin
                n_fail++;
                $display("FAIL dir%0d rdata/fault: got %h/%b want %h/%b", i, ob.rdata, ob.fault,
                         tbl[i].e_rdata, tbl[i].e_fault);
            end
            n_checks++;
            if (ob.addr !== ea || ob.rd !== tbl[i].rd || ob.is_load !== !tbl[i].st) begin
                n_fail++;
                $display("FAIL dir%0d resp_fields: got addr=%h rd=%0d ld=%b want %h %0d %b", i,
                         ob.addr, ob.rd, ob.is_load, ea, tbl[i].rd, !tbl[i].st);
            end
            n_checks++;
            if (ob.nrd !== tbl[i].e_nrd || ob.nwr !== tbl[i].e_nwr || ob.op_err !== 0) begin
                n_fail++;
                $display("FAIL dir%0d strobes: got rd=%0d wr=%0d operr=%0d want %0d %0d 0", i,
                         ob.nrd, ob.nwr, ob.op_err, tbl[i].e_nrd, tbl[i].e_nwr);
            end
            if (ob.nwr > 0) begin
                n_checks++;
                if (ob.wr_addr !== (ea & ~32'h3) || ob.wr_data !== tbl[i].e_wrdata) begin
                    n_fail++;
                    $display("FAIL dir%0d write: got %h@%h want %h@%h", i, ob.wr_data, ob.wr_addr,
                             tbl[i].e_wrdata, ea & ~32'h3);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL resp_pulse: got valid=%b one cycle later want 0", bus.resp_valid);
        end
    endtask

    task automatic test_abort();
        obs_t ob;
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3   = 3'b000;
        bus.req_base     = 32'h100;
        bus.req_offset   = 32'h0;
        bus.req_wdata    = 32'h000000AA;
        bus.req_rd       = 5'd4;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL abort_rd_phase: got rd=%b wr=%b want 1 0", bus.mem_rd_en, bus.mem_wr_en);
        end
        @(negedge clk);
        n_checks++;
        if (bus.mem_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL abort_wr_phase: got wr=%b want 1", bus.mem_wr_en);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_async: got wr=%b rd=%b ready=%b want 0 0 1", bus.mem_wr_en,
                     bus.mem_rd_en, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_resp: got valid=%b at cycle %0d want 0", bus.resp_valid, c);
            end
        end
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd2, ob);
        n_checks++;
        if (ob.rdata !== 32'hDEAD55EF || ob.rdata !== ref_word(32'h100) || ob.lat !== 3) begin
            n_fail++; $display("FAIL abort_readback: got %h lat %0d want DEAD55EF lat 3", ob.rdata, ob.lat);
        end
    endtask

    task automatic test_random();
        obs_t        ob;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] ea, off, wd;
        logic [4:0]  rd;
        logic [31:0] e_rdata, e_wrdata;
        logic [1:0]  e_fault;
        int          e_lat, e_nrd, e_nwr;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) @(negedge clk);
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            ea = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) begin
                if (f3[1:0] == 2'b10) ea[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) ea[0] = 1'b0;
            end
            off = 32'($urandom_range(0, 255)) - 32'd128;
            wd  = $urandom;
            rd  = 5'($urandom_range(0, 31));
            model(st, f3, ea, wd, e_rdata, e_fault, e_lat, e_nrd, e_nwr, e_wrdata);
            do_req(st, f3, ea - off, off, wd, rd, ob);
            n_checks++;
            if (ob.ready !== 1'b1 || ob.lat !== e_lat) begin
                n_fail++; $display("FAIL rnd%0d timing: got ready=%b lat=%0d want 1 %0d", i, ob.ready, ob.lat, e_lat);
            end
            n_checks++;
            if (ob.rdata !== e_rdata || ob.fault !== e_fault || ob.addr !== ea || ob.rd !== rd ||
                ob.is_load !== !st) begin
                n_fail++;
                $display("FAIL rnd%0d resp: got %h/%b/%h/%0d/%b want %h/%b/%h/%0d/%b", i, ob.rdata,
                         ob.fault, ob.addr, ob.rd, ob.is_load, e_rdata, e_fault, ea, rd, !st);
            end
            n_checks++;
            if (ob.nrd !== e_nrd || ob.nwr !== e_nwr || ob.op_err !== 0) begin
                n_fail++;
                $display("FAIL rnd%0d strobes: got rd=%0d wr=%0d operr=%0d want %0d %0d 0", i,
                         ob.nrd, ob.nwr, ob.op_err, e_nrd, e_nwr);
            end
            if (ob.nrd > 0) begin
                n_checks++;
                if (ob.rd_addr !== (ea & ~32'h3)) begin
                    n_fail++; $display("FAIL rnd%0d rd_addr: got %h want %h", i, ob.rd_addr, ea & ~32'h3);
                end
            end
            if (ob.nwr > 0) begin
                n_checks++;
                if (ob.wr_addr !== (ea & ~32'h3) || ob.wr_data !== e_wrdata) begin
                    n_fail++;
                    $display("FAIL rnd%0d write: got %h@%h want %h@%h", i, ob.wr_data, ob.wr_addr,
                             e_wrdata, ea & ~32'h3);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_base     = '0;
        bus.req_offset   = '0;
        bus.req_wdata    = '0;
        bus.req_rd       = '0;
        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
        end
        test_reset();
        test_directed();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end
endmodule
